// File: rtl/seq_adder.sv
// Bit-serial adder: one result bit per clock, LSB first.
// Operands are captured on start; s/c update only when an addition completes.
module seq_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // IDLE : waiting for start
    // RUN  : one operand bit per edge, WIDTH edges
    // DONE : results valid, single-cycle done pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_k;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;

    logic             w_half;
    logic             w_bit;
    logic             w_carry_next;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Full adder built as two half-adder stages plus an OR.
    always_comb begin
        w_half       = r_a[0] ^ r_b[0];
        w_bit        = w_half ^ r_k;
        w_carry_next = (r_a[0] & r_b[0]) | (r_k & w_half);
        w_last       = (r_cnt == CW'(WIDTH - 1));
        w_sum_next   = r_sum >> 1;
        w_sum_next[WIDTH-1] = w_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= 1'b0;
            r_sum <= '0;
            r_cnt <= '0;
            r_s   <= '0;
            r_c   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a   <= a;
                r_b   <= b;
                r_k   <= cin;
                r_sum <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_k   <= w_carry_next;
            r_sum <= w_sum_next;
            r_cnt <= r_cnt + CW'(1);
            // Publish only on the final bit so partial sums never reach s/c.
            if (w_last) begin
                r_s <= w_sum_next;
                r_c <= w_carry_next;
            end
        end
    end

    assign s = r_s;
    assign c = r_c;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder at WIDTH = 8, 1 and 16.
// Expected sums come from plain integer arithmetic; timing is counted in edges.
module tb_seq_adder;

    logic clk;
    logic rst;
    int   sel;
    logic        start_drv;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        cin_drv;

    logic start8, start1, start16;
    logic busy8, done8, c8;
    logic busy1, done1, c1;
    logic busy16, done16, c16;
    logic [7:0]  s8;
    logic [0:0]  s1;
    logic [15:0] s16;

    int n_asserts;
    int n_fail;

    assign start8  = start_drv && (sel == 0);
    assign start1  = start_drv && (sel == 1);
    assign start16 = start_drv && (sel == 2);

    seq_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_drv[7:0]), .b(b_drv[7:0]),
        .cin(cin_drv), .busy(busy8), .done(done8), .s(s8), .c(c8)
    );
    seq_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a_drv[0:0]), .b(b_drv[0:0]),
        .cin(cin_drv), .busy(busy1), .done(done1), .s(s1), .c(c1)
    );
    seq_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a_drv), .b(b_drv),
        .cin(cin_drv), .busy(busy16), .done(done16), .s(s16), .c(c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] exp;
        bit          hold;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cur_w();
        case (sel)
            0:       return 8;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            0:       return busy8;
            1:       return busy1;
            default: return busy16;
        endcase
    endfunction

    function automatic logic cur_done();
        case (sel)
            0:       return done8;
            1:       return done1;
            default: return done16;
        endcase
    endfunction

    function automatic logic [16:0] cur_res();
        case (sel)
            0:       return 17'({c8, s8});
            1:       return 17'({c1, s1});
            default: return 17'({c16, s16});
        endcase
    endfunction

    function automatic logic [16:0] ref_add(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic ci);
        longint m;
        longint sum;
        m   = (longint'(1) << w) - 1;
        sum = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
        return 17'(sum % (longint'(1) << (w + 1)));
    endfunction

    // Launch one addition, scramble operands after acceptance, then check
    // busy length, done latency (in edges from acceptance), result and pulse width.
    task automatic do_op(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic [16:0] exp);
        int w;
        int done_k;
        int busy_n;
        int unstable;
        logic [16:0] res0;
        w        = cur_w();
        done_k   = -1;
        busy_n   = 0;
        unstable = 0;
        a_drv     = x;
        b_drv     = y;
        cin_drv   = ci;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        a_drv     = ~x;
        b_drv     = ~y;
        cin_drv   = ~ci;
        res0      = cur_res();
        for (int k = 0; k < w + 6 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (cur_done()) begin
                done_k = k;
            end else begin
                if (cur_busy()) busy_n++;
                if (cur_res() !== res0) unstable++;
            end
        end
        chk({name, " done_latency"}, 32'(done_k + 1), 32'(w + 1));
        chk({name, " busy_cycles"}, 32'(busy_n), 32'(w));
        chk({name, " stable_during_run"}, 32'(unstable), 32'd0);
        chk({name, " busy_in_done"}, 32'(cur_busy()), 32'd0);
        chk({name, " result"}, 32'(cur_res()), 32'(exp));
        @(posedge clk); #1;
        chk({name, " done_one_cycle"}, 32'(cur_done()), 32'd0);
    endtask

    initial begin
        int ndone;
        int changes;
        logic [16:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        n_asserts = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sel       = 0;
        start_drv = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        cin_drv   = 1'b0;

        vecs[0] = '{0, 16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0};
        vecs[1] = '{0, 16'h005A, 16'h0025, 1'b1, 17'h00080, 1'b1};
        vecs[2] = '{1, 16'h0000, 16'h0000, 1'b0, 17'd0, 1'b0};
        vecs[3] = '{1, 16'h0000, 16'h0000, 1'b1, 17'd1, 1'b0};
        vecs[4] = '{1, 16'h0000, 16'h0001, 1'b0, 17'd1, 1'b0};
        vecs[5] = '{1, 16'h0000, 16'h0001, 1'b1, 17'd2, 1'b0};
        vecs[6] = '{1, 16'h0001, 16'h0000, 1'b0, 17'd1, 1'b0};
        vecs[7] = '{1, 16'h0001, 16'h0000, 1'b1, 17'd2, 1'b0};
        vecs[8] = '{1, 16'h0001, 16'h0001, 1'b0, 17'd2, 1'b0};
        vecs[9] = '{1, 16'h0001, 16'h0001, 1'b1, 17'd3, 1'b0};

        #12;
        chk("reset busy8", 32'(busy8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset res8", 32'({c8, s8}), 32'd0);
        chk("reset busy1", 32'(busy1 | done1), 32'd0);
        chk("reset res16", 32'({busy16, done16, c16, s16}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].sel;
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp);
            if (vecs[i].hold) begin
                held    = cur_res();
                changes = 0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    if (cur_res() !== held || cur_done() || cur_busy()) changes++;
                end
                chk("hold_after_done", 32'(changes), 32'd0);
            end
        end

        // Start held high: back-to-back operations, operands changed mid-run.
        sel       = 0;
        a_drv     = 16'h0011;
        b_drv     = 16'h0022;
        cin_drv   = 1'b0;
        start_drv = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 0) begin
                a_drv = 16'h00F0;
                b_drv = 16'h0020;
            end
            if (k == 11) begin
                a_drv = 16'h0077;
                b_drv = 16'h0077;
            end
            if (k == 12) start_drv = 1'b0;
            if (done8) begin
                ndone++;
                if (ndone == 1) begin
                    chk("b2b first_done_edge", 32'(k + 1), 32'd9);
                    chk("b2b first_result", 32'(cur_res()), 32'(ref_add(8, 16'h11, 16'h22, 1'b0)));
                end else if (ndone == 2) begin
                    chk("b2b second_done_edge", 32'(k + 1), 32'd19);
                    chk("b2b second_result", 32'(cur_res()), 32'(ref_add(8, 16'hF0, 16'h20, 1'b0)));
                end
            end
        end
        chk("b2b done_count", 32'(ndone), 32'd2);

        // Asynchronous reset in the middle of RUN.
        a_drv     = 16'h00AA;
        b_drv     = 16'h0055;
        cin_drv   = 1'b1;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort busy_before", 32'(busy8), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort sc", 32'({c8, s8}), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("abort in_reset", 32'({busy8, done8, c8, s8}), 32'd0);
        rst = 1'b0;
        do_op("post_reset", 16'h0003, 16'h0004, 1'b0, 17'h00007);

        // Random operands at WIDTH = 16.
        sel = 2;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            do_op($sformatf("rand%0d", i), ra, rb, rc, ref_add(16, ra, rb, rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
